tag_credit_control: RTL and testbench
=====================================

TAG_CREDIT_CONTROL -- requirements
Module: tag_credit_control

Interface
REQ-001 SHALL have parameter TAG_COUNT, default 256, number of tag encodings (8-bit tag space).
REQ-002 SHALL have parameter CREDITS_READ, default 32, maximum read commands in flight.
REQ-003 SHALL have parameter CREDITS_WRITE, default 32, maximum write commands in flight; CREDITS_READ+CREDITS_WRITE SHALL NOT exceed 64.
REQ-004 SHALL have port clock  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port enabled_in  in  1  job running; low blocks grants.
REQ-007 SHALL have port croom_in  in  8  PSL command room, sampled on enabled_in rising edge.
REQ-008 SHALL have port req_valid_in  in  1  arbiter requests a command slot.
REQ-009 SHALL have port req_is_write_in  in  1  1=write class, 0=read class.
REQ-010 SHALL have port grant_out  in/out: out  1  slot granted this cycle.
REQ-011 SHALL have port tag_out  out  8  tag for granted command; valid only with grant_out.
REQ-012 SHALL have port rsp_valid_in  in  1  PSL response returns a tag.
REQ-013 SHALL have port rsp_tag_in  in  8  returned tag.
REQ-014 SHALL have port rsp_is_write_in  in  1  class of returned command.
REQ-015 SHALL have port ready_out  out  1  free list initialised and enabled.
REQ-016 SHALL have port error_out  out  1  sticky: return of INVALID_TAG, return while nothing outstanding in that class, or grant/credit overflow.

Function
REQ-017 SHALL implement FSM states IDLE, INIT, READY.
REQ-018 IDLE->INIT when enabled_in=1; INIT pushes tags 1..TAG_COUNT-1 into free-list FIFO, one per cycle (255 cycles); INIT->READY after tag 255 pushed.
REQ-019 Tag 0 (INVALID_TAG) SHALL never be issued.
REQ-020 Total credit limit SHALL be min(croom_in, CREDITS_READ+CREDITS_WRITE), latched on entry to INIT.
REQ-021 grant_out SHALL be combinational: READY & enabled_in & req_valid_in & free list non-empty & class outstanding < class limit & total outstanding < total limit.
REQ-022 tag_out SHALL equal free-list head; grant pops it the same edge.
REQ-023 rsp_valid_in with valid tag SHALL push rsp_tag_in into free list and decrement that class outstanding counter on the next edge.
REQ-024 Simultaneous grant and return: both execute; same-class counter unchanged; FIFO pop and push both occur; returned tag not reissuable before the next cycle.
REQ-025 Invalid return (tag 0 or class counter 0) SHALL be dropped and set error_out; counters unchanged.
REQ-026 enabled_in falling in READY: grants stop; returns still accepted; FSM stays READY.
REQ-027 ready_out = (state==READY) & enabled_in.
REQ-028 Outstanding counters SHALL be 7 bits, never wrap; free list depth TAG_COUNT, full never reached in legal use.

Reset
REQ-029 reset SHALL, on the next edge, force IDLE, empty free list, clear outstanding counters, total limit 0, error_out 0; grant_out 0, ready_out 0, tag_out 0.
REQ-030 reset mid-INIT or mid-READY SHALL discard all in-flight tags; post-reset returns are treated as invalid.

Structure
REQ-031 TAG_COUNT, INVALID_TAG, CREDITS_READ, CREDITS_WRITE and the FSM state enum SHALL live in the shared globals package.
REQ-032 Free list SHALL be a sub-module fifo_tag_free_list (depth TAG_COUNT, width 8, push/pop/empty).

Verification
REQ-033 Reset, enabled_in=1, croom_in=64 -> ready_out rises after 255 INIT cycles; first grant tag_out=1, second tag_out=2.
REQ-034 Continuous read requests, no returns -> exactly 32 grants, then grant_out=0; one read return -> one further grant.
REQ-035 croom_in=20, mixed requests -> total outstanding never exceeds 20.
REQ-036 Grant and return same cycle with 32 reads outstanding -> read counter stays 32, returned tag issued later.
REQ-037 rsp_tag_in=0 or write return with 0 writes outstanding -> error_out=1 sticky, counters unchanged.
REQ-038 reset asserted mid-INIT -> IDLE next cycle, ready_out=0, full 255-cycle re-init on re-enable.

Source files
------------

// File: rtl/tag_credit_control_pkg.sv
// Shared constants, FSM state type and credit-limit helper for the tag credit controller.
package tag_credit_control_pkg;

  localparam int TAG_COUNT = 256;
  localparam int TAG_W = 8;
  localparam logic [7:0] INVALID_TAG = 8'd0;
  localparam int CREDITS_READ = 32;
  localparam int CREDITS_WRITE = 32;

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    READY
  } tcc_state_e;

  // Total in-flight limit: the smaller of PSL command room and our own credit pool.
  function automatic logic [6:0] credit_limit(input logic [7:0] room, input int cap);
    if (int'(room) > cap) begin
      return 7'(cap);
    end
    return room[6:0];
  endfunction

endpackage

// File: rtl/tag_credit_control_fifo.sv
// Free-tag FIFO: holds tags available for issue; head is visible combinationally.
module fifo_tag_free_list
  import tag_credit_control_pkg::*;
#(
  parameter int DEPTH = TAG_COUNT,
  parameter int WIDTH = TAG_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign head_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= (wr_ptr_q == AW'(DEPTH-1)) ? '0 : wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == AW'(DEPTH-1)) ? '0 : rd_ptr_q + AW'(1);
      end
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage needs no reset; pointers alone define what is valid.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/tag_credit_control.sv
// Issues command tags from a free list under per-class and total credit limits,
// recycles returned tags, and flags illegal returns with a sticky error.
module tag_credit_control #(
  parameter int TAG_COUNT     = tag_credit_control_pkg::TAG_COUNT,
  parameter int CREDITS_READ  = tag_credit_control_pkg::CREDITS_READ,
  parameter int CREDITS_WRITE = tag_credit_control_pkg::CREDITS_WRITE
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enabled_in,
  input  logic [7:0] croom_in,
  input  logic       req_valid_in,
  input  logic       req_is_write_in,
  output logic       grant_out,
  output logic [7:0] tag_out,
  input  logic       rsp_valid_in,
  input  logic [7:0] rsp_tag_in,
  input  logic       rsp_is_write_in,
  output logic       ready_out,
  output logic       error_out
);

  localparam int         CREDITS_TOTAL = CREDITS_READ + CREDITS_WRITE;
  localparam logic [7:0] LAST_TAG      = 8'(TAG_COUNT - 1);
  localparam logic [6:0] RD_LIM        = 7'(CREDITS_READ);
  localparam logic [6:0] WR_LIM        = 7'(CREDITS_WRITE);

  tag_credit_control_pkg::tcc_state_e state_q, state_d;
  logic [7:0] init_tag_q, init_tag_d;
  logic [6:0] rd_out_q, rd_out_d, wr_out_q, wr_out_d;
  logic [6:0] total_lim_q, total_lim_d;
  logic       error_q, error_d;

  logic       fl_push, fl_pop, fl_empty, fl_full, init_push;
  logic [7:0] fl_push_data, fl_head;
  logic [7:0] total_out;
  logic       class_ok, grant, rsp_cnt_nz, ret_ok, ret_bad;

  always_comb begin
    total_out  = {1'b0, rd_out_q} + {1'b0, wr_out_q};
    class_ok   = req_is_write_in ? (wr_out_q < WR_LIM) : (rd_out_q < RD_LIM);
    grant      = (state_q == tag_credit_control_pkg::READY) & enabled_in & req_valid_in
               & ~fl_empty & class_ok & (total_out < {1'b0, total_lim_q});
    rsp_cnt_nz = rsp_is_write_in ? (wr_out_q != '0) : (rd_out_q != '0);
    ret_ok     = rsp_valid_in & (rsp_tag_in != tag_credit_control_pkg::INVALID_TAG) & rsp_cnt_nz;
    ret_bad    = rsp_valid_in & ~ret_ok;
  end

  always_comb begin
    state_d     = state_q;
    init_tag_d  = init_tag_q;
    total_lim_d = total_lim_q;
    init_push   = 1'b0;
    unique case (state_q)
      tag_credit_control_pkg::IDLE: begin
        if (enabled_in) begin
          state_d     = tag_credit_control_pkg::INIT;
          init_tag_d  = 8'd1;
          total_lim_d = tag_credit_control_pkg::credit_limit(croom_in, CREDITS_TOTAL);
        end
      end
      tag_credit_control_pkg::INIT: begin
        init_push  = 1'b1;
        init_tag_d = init_tag_q + 8'd1;
        if (init_tag_q == LAST_TAG) begin
          state_d = tag_credit_control_pkg::READY;
        end
      end
      tag_credit_control_pkg::READY: begin
        state_d = tag_credit_control_pkg::READY;
      end
      default: state_d = tag_credit_control_pkg::IDLE;
    endcase
  end

  // A same-class grant and return cancel out, so the counter holds.
  always_comb begin
    rd_out_d     = rd_out_q + 7'(grant & ~req_is_write_in) - 7'(ret_ok & ~rsp_is_write_in);
    wr_out_d     = wr_out_q + 7'(grant & req_is_write_in) - 7'(ret_ok & rsp_is_write_in);
    fl_push      = init_push | ret_ok;
    fl_push_data = init_push ? init_tag_q : rsp_tag_in;
    fl_pop       = grant;
    error_d      = error_q | ret_bad | (fl_push & fl_full & ~fl_pop);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= tag_credit_control_pkg::IDLE;
      init_tag_q  <= '0;
      rd_out_q    <= '0;
      wr_out_q    <= '0;
      total_lim_q <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_tag_q  <= init_tag_d;
      rd_out_q    <= rd_out_d;
      wr_out_q    <= wr_out_d;
      total_lim_q <= total_lim_d;
      error_q     <= error_d;
    end
  end

  fifo_tag_free_list #(
    .DEPTH(TAG_COUNT),
    .WIDTH(8)
  ) u_free_list (
    .clock      (clock),
    .reset      (reset),
    .push_i     (fl_push),
    .push_data_i(fl_push_data),
    .pop_i      (fl_pop),
    .head_o     (fl_head),
    .empty_o    (fl_empty),
    .full_o     (fl_full)
  );

  assign grant_out = grant;
  assign tag_out   = grant ? fl_head : 8'd0;
  assign ready_out = (state_q == tag_credit_control_pkg::READY) & enabled_in;
  assign error_out = error_q;

endmodule

// File: tb/tb_tag_credit_control.sv
// Scoreboard bench: a reference free-list queue and per-class outstanding lists predict every grant and tag.
module tb_tag_credit_control;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enabled_in = 1'b0;
  logic [7:0] croom_in = 8'd0;
  logic       req_valid_in = 1'b0;
  logic       req_is_write_in = 1'b0;
  logic       rsp_valid_in = 1'b0;
  logic [7:0] rsp_tag_in = 8'd0;
  logic       rsp_is_write_in = 1'b0;
  logic       grant_out, ready_out, error_out;
  logic [7:0] tag_out;

  tag_credit_control dut (
    .clock          (clock),
    .reset          (reset),
    .enabled_in     (enabled_in),
    .croom_in       (croom_in),
    .req_valid_in   (req_valid_in),
    .req_is_write_in(req_is_write_in),
    .grant_out      (grant_out),
    .tag_out        (tag_out),
    .rsp_valid_in   (rsp_valid_in),
    .rsp_tag_in     (rsp_tag_in),
    .rsp_is_write_in(rsp_is_write_in),
    .ready_out      (ready_out),
    .error_out      (error_out)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] freeQ[$];
  logic [7:0] outRd[$];
  logic [7:0] outWr[$];
  int mLim = 0;
  bit mReady = 0;
  bit mErr = 0;

  function automatic bit predGrant();
    int rd = outRd.size();
    int wr = outWr.size();
    return mReady && enabled_in && req_valid_in && (freeQ.size() > 0)
        && (req_is_write_in ? (wr < 32) : (rd < 32)) && ((rd + wr) < mLim);
  endfunction

  function automatic bit predRetOk();
    return rsp_valid_in && (rsp_tag_in != 8'd0)
        && (rsp_is_write_in ? (outWr.size() > 0) : (outRd.size() > 0));
  endfunction

  task automatic drive(input bit req, input bit isWr, input bit rsp, input logic [7:0] rtag, input bit rWr);
    req_valid_in = req;
    req_is_write_in = isWr;
    rsp_valid_in = rsp;
    rsp_tag_in = rtag;
    rsp_is_write_in = rWr;
    #1;
  endtask

  // Commits one clock edge and moves the reference model forward with it.
  task automatic advance();
    bit g, ok, bad, gWr, rWr;
    logic [7:0] gtag, rtag;
    g = predGrant();
    ok = predRetOk();
    bad = rsp_valid_in && !ok;
    gtag = g ? freeQ[0] : 8'd0;
    rtag = rsp_tag_in;
    gWr = req_is_write_in;
    rWr = rsp_is_write_in;
    @(posedge clock);
    #1;
    if (g) begin
      void'(freeQ.pop_front());
      if (gWr) outWr.push_back(gtag);
      else outRd.push_back(gtag);
    end
    if (ok) begin
      if (rWr) begin
        for (int i = 0; i < outWr.size(); i++) if (outWr[i] == rtag) begin outWr.delete(i); break; end
      end else begin
        for (int i = 0; i < outRd.size(); i++) if (outRd[i] == rtag) begin outRd.delete(i); break; end
      end
      freeQ.push_back(rtag);
    end
    if (bad) mErr = 1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    enabled_in = 1'b0;
    drive(0, 0, 0, 8'd0, 0);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    freeQ.delete();
    outRd.delete();
    outWr.delete();
    mReady = 0;
    mErr = 0;
    mLim = 0;
  endtask

  task automatic doInit(input logic [7:0] room, output int cyc);
    croom_in = room;
    enabled_in = 1'b1;
    cyc = 0;
    while (ready_out !== 1'b1 && cyc < 400) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    mReady = 1;
    mLim = (room > 8'd64) ? 64 : int'(room);
    for (int t = 1; t < 256; t++) freeQ.push_back(8'(t));
  endtask

  task automatic test_reset();
    doReset();
    drive(1, 0, 0, 8'd0, 0);
    vectors++; if (grant_out !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_grant: got %b expected 0", grant_out); end
    vectors++; if (tag_out !== 8'd0) begin miscompares++; $display("[TB] FAIL reset_tag: got %0d expected 0", tag_out); end
    vectors++; if (ready_out !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ready: got %b expected 0", ready_out); end
    vectors++; if (error_out !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_error: got %b expected 0", error_out); end
    drive(0, 0, 1, 8'd5, 0);
    advance();
    drive(0, 0, 0, 8'd0, 0);
    vectors++; if (error_out !== 1'b1) begin miscompares++; $display("[TB] FAIL post_reset_return_err: got %b expected 1", error_out); end
    doReset();
    vectors++; if (error_out !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_clears_err: got %b expected 0", error_out); end
  endtask

  task automatic test_init_first_grants();
    int cyc;
    doInit(8'd64, cyc);
    vectors++; if (cyc !== 256) begin miscompares++; $display("[TB] FAIL init_cycles: got %0d expected 256", cyc); end
    drive(1, 0, 0, 8'd0, 0);
    vectors++; if (grant_out !== 1'b1) begin miscompares++; $display("[TB] FAIL first_grant: got %b expected 1", grant_out); end
    vectors++; if (tag_out !== 8'd1) begin miscompares++; $display("[TB] FAIL first_tag: got %0d expected 1", tag_out); end
    advance();
    drive(1, 0, 0, 8'd0, 0);
    vectors++; if (tag_out !== 8'd2) begin miscompares++; $display("[TB] FAIL second_tag: got %0d expected 2", tag_out); end
    advance();
  endtask

  task automatic test_read_credit_limit();
    int dutGrants = 0;
    for (int i = 0; i < 40; i++) begin
      drive(1, 0, 0, 8'd0, 0);
      vectors++; if (grant_out !== predGrant()) begin miscompares++; $display("[TB] FAIL rd_limit_grant[%0d]: got %b expected %b", i, grant_out, predGrant()); end
      if (predGrant()) begin
        vectors++; if (tag_out !== freeQ[0]) begin miscompares++; $display("[TB] FAIL rd_limit_tag[%0d]: got %0d expected %0d", i, tag_out, freeQ[0]); end
      end
      if (grant_out === 1'b1) dutGrants++;
      advance();
    end
    vectors++; if (dutGrants !== 30) begin miscompares++; $display("[TB] FAIL rd_limit_count: got %0d expected 30", dutGrants); end
    drive(1, 0, 1, outRd[0], 0);
    vectors++; if (grant_out !== 1'b0) begin miscompares++; $display("[TB] FAIL rd_full_with_return: got %b expected 0", grant_out); end
    advance();
    drive(1, 0, 0, 8'd0, 0);
    vectors++; if (grant_out !== 1'b1) begin miscompares++; $display("[TB] FAIL rd_regrant: got %b expected 1", grant_out); end
    vectors++; if (tag_out !== 8'd33) begin miscompares++; $display("[TB] FAIL rd_regrant_tag: got %0d expected 33", tag_out); end
    advance();
    drive(1, 0, 0, 8'd0, 0);
    vectors++; if (grant_out !== 1'b0) begin miscompares++; $display("[TB] FAIL rd_full_again: got %b expected 0", grant_out); end
    advance();
  endtask

  task automatic test_back_to_back();
    logic [7:0] rt;
    drive(1, 0, 1, outRd[0], 0);
    advance();
    rt = outRd[0];
    drive(1, 0, 1, rt, 0);
    vectors++; if (grant_out !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_grant: got %b expected 1", grant_out); end
    vectors++; if (tag_out !== freeQ[0] || tag_out === rt) begin miscompares++; $display("[TB] FAIL b2b_tag: got %0d expected %0d", tag_out, freeQ[0]); end
    advance();
    drive(1, 0, 0, 8'd0, 0);
    vectors++; if (grant_out !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_counter_held: got %b expected 1", grant_out); end
    advance();
    drive(1, 0, 0, 8'd0, 0);
    vectors++; if (grant_out !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_full: got %b expected 0", grant_out); end
    advance();
  endtask

  task automatic test_errors();
    drive(0, 0, 1, 8'd0, 0);
    advance();
    drive(0, 0, 0, 8'd0, 0);
    vectors++; if (error_out !== 1'b1) begin miscompares++; $display("[TB] FAIL err_tag0: got %b expected 1", error_out); end
    drive(0, 0, 1, outRd[0], 1);
    advance();
    drive(1, 0, 0, 8'd0, 0);
    vectors++; if (error_out !== 1'b1) begin miscompares++; $display("[TB] FAIL err_wr_empty: got %b expected 1", error_out); end
    vectors++; if (grant_out !== 1'b0) begin miscompares++; $display("[TB] FAIL err_rd_unchanged: got %b expected 0", grant_out); end
    drive(1, 1, 0, 8'd0, 0);
    vectors++; if (grant_out !== 1'b1) begin miscompares++; $display("[TB] FAIL err_wr_unchanged: got %b expected 1", grant_out); end
    vectors++; if (tag_out !== freeQ[0]) begin miscompares++; $display("[TB] FAIL err_wr_tag: got %0d expected %0d", tag_out, freeQ[0]); end
    advance();
    drive(0, 0, 1, outWr[0], 1);
    advance();
    drive(0, 0, 0, 8'd0, 0);
    vectors++; if (error_out !== 1'b1) begin miscompares++; $display("[TB] FAIL err_sticky: got %b expected 1", error_out); end
  endtask

  task automatic test_enable_low();
    enabled_in = 1'b0;
    drive(1, 0, 1, outRd[0], 0);
    vectors++; if (grant_out !== 1'b0) begin miscompares++; $display("[TB] FAIL dis_grant: got %b expected 0", grant_out); end
    vectors++; if (ready_out !== 1'b0) begin miscompares++; $display("[TB] FAIL dis_ready: got %b expected 0", ready_out); end
    advance();
    enabled_in = 1'b1;
    drive(1, 0, 0, 8'd0, 0);
    vectors++; if (ready_out !== 1'b1) begin miscompares++; $display("[TB] FAIL reen_ready: got %b expected 1", ready_out); end
    vectors++; if (grant_out !== predGrant()) begin miscompares++; $display("[TB] FAIL reen_grant: got %b expected %b", grant_out, predGrant()); end
    advance();
  endtask

  task automatic test_croom_limit();
    int cyc, dutOut, maxOut;
    bit req, isWr, rsp, rWr;
    logic [7:0] rtag;
    doReset();
    doInit(8'd20, cyc);
    vectors++; if (cyc !== 256) begin miscompares++; $display("[TB] FAIL croom_init_cycles: got %0d expected 256", cyc); end
    dutOut = 0;
    maxOut = 0;
    for (int i = 0; i < 300; i++) begin
      req = ($urandom % 4) != 0;
      isWr = $urandom % 2;
      rsp = 0; rWr = 0; rtag = 8'd0;
      if (($urandom % 3) == 0 && (outRd.size() + outWr.size()) > 0) begin
        rsp = 1;
        rWr = (outRd.size() == 0) ? 1'b1 : (outWr.size() == 0) ? 1'b0 : 1'($urandom % 2);
        rtag = rWr ? outWr[$urandom_range(outWr.size() - 1)] : outRd[$urandom_range(outRd.size() - 1)];
      end
      drive(req, isWr, rsp, rtag, rWr);
      vectors++; if (grant_out !== predGrant()) begin miscompares++; $display("[TB] FAIL croom_grant[%0d]: got %b expected %b", i, grant_out, predGrant()); end
      if (predGrant()) begin
        vectors++; if (tag_out !== freeQ[0]) begin miscompares++; $display("[TB] FAIL croom_tag[%0d]: got %0d expected %0d", i, tag_out, freeQ[0]); end
      end
      if (grant_out === 1'b1) dutOut++;
      if (dutOut > maxOut) maxOut = dutOut;
      advance();
      if (rsp) dutOut--;
    end
    drive(0, 0, 0, 8'd0, 0);
    vectors++; if (maxOut !== 20) begin miscompares++; $display("[TB] FAIL croom_max_outstanding: got %0d expected 20", maxOut); end
    vectors++; if (error_out !== 1'b0) begin miscompares++; $display("[TB] FAIL croom_no_error: got %b expected 0", error_out); end
  endtask

  task automatic test_reset_mid_init();
    int cyc;
    doReset();
    croom_in = 8'd64;
    enabled_in = 1'b1;
    for (int i = 0; i < 100; i++) begin @(posedge clock); #1; end
    reset = 1'b1;
    enabled_in = 1'b0;
    @(posedge clock);
    #1;
    vectors++; if (ready_out !== 1'b0) begin miscompares++; $display("[TB] FAIL midinit_ready: got %b expected 0", ready_out); end
    reset = 1'b0;
    freeQ.delete(); outRd.delete(); outWr.delete();
    mReady = 0; mErr = 0; mLim = 0;
    doInit(8'd64, cyc);
    vectors++; if (cyc !== 256) begin miscompares++; $display("[TB] FAIL midinit_reinit_cycles: got %0d expected 256", cyc); end
    drive(1, 1, 0, 8'd0, 0);
    vectors++; if (tag_out !== 8'd1) begin miscompares++; $display("[TB] FAIL midinit_first_tag: got %0d expected 1", tag_out); end
    advance();
    drive(0, 0, 0, 8'd0, 0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_init_first_grants();
    test_read_credit_limit();
    test_back_to_back();
    test_errors();
    test_enable_low();
    test_croom_limit();
    test_reset_mid_init();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
